// File: rtl/data_memory_arbiter.sv
// Round-robin arbiter sharing the single-port data memory bus between the core LSU (m0)
// and the AES loader (m1), with beat-limited locking and a data-window range check.
module data_memory_arbiter #(
    parameter logic [31:0] DATA_BEGIN     = 32'h0000_2000,
    parameter logic [31:0] DATA_END       = 32'h0000_3FFF,
    parameter int unsigned MAX_LOCK_BEATS = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        m0_req_valid,
    output logic        m0_req_ready,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_byte_en,
    input  logic        m0_we,
    input  logic        m0_lock,
    output logic        m0_rsp_valid,
    output logic [31:0] m0_rsp_rdata,
    output logic        m0_rsp_err,
    input  logic        m1_req_valid,
    output logic        m1_req_ready,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_byte_en,
    input  logic        m1_we,
    input  logic        m1_lock,
    output logic        m1_rsp_valid,
    output logic [31:0] m1_rsp_rdata,
    output logic        m1_rsp_err,
    output logic [31:0] bus_address,
    output logic [31:0] bus_write_data,
    output logic [3:0]  bus_byte_enable,
    output logic        bus_read_enable,
    output logic        bus_write_enable,
    input  logic [31:0] bus_read_data
);

    localparam int unsigned      CNT_W   = $clog2(MAX_LOCK_BEATS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_LOCK_BEATS);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACCESS = 1'b1;

    logic [0:0]       state;
    logic             last_grant;
    logic             lock_held;
    logic             lock_owner;
    logic [CNT_W-1:0] lock_cnt;
    logic [CNT_W-1:0] lock_cnt_inc;

    logic             cur_g;
    logic             cur_we;
    logic             cur_in_range;

    logic [31:0]      m0_rdata_q;
    logic [31:0]      m1_rdata_q;
    logic             m0_err_q;
    logic             m1_err_q;

    logic             elig0;
    logic             elig1;
    logic             grant_any;
    logic             g;
    logic [31:0]      sel_addr;
    logic [31:0]      sel_wdata;
    logic [3:0]       sel_be;
    logic             sel_we;
    logic             sel_lock;
    logic             sel_in_range;
    logic             in_access;
    logic [31:0]      rsp_rdata;
    logic             rsp_err;

    always_comb begin
        // While a lock is held only its owner may be granted.
        elig0 = m0_req_valid && (!lock_held || !lock_owner);
        elig1 = m1_req_valid && (!lock_held ||  lock_owner);
        g     = (elig0 && elig1) ? ~last_grant : ~elig0;
        grant_any = !reset && (state == ST_IDLE) && (elig0 || elig1);

        sel_addr  = g ? m1_addr    : m0_addr;
        sel_wdata = g ? m1_wdata   : m0_wdata;
        sel_be    = g ? m1_byte_en : m0_byte_en;
        sel_we    = g ? m1_we      : m0_we;
        sel_lock  = g ? m1_lock    : m0_lock;
        sel_in_range = (sel_addr >= DATA_BEGIN) && (sel_addr <= DATA_END);

        m0_req_ready = grant_any && !g;
        m1_req_ready = grant_any &&  g;

        bus_address      = sel_addr;
        bus_write_data   = sel_wdata;
        bus_byte_enable  = sel_be;
        bus_read_enable  = grant_any && !sel_we;
        bus_write_enable = grant_any && sel_we && sel_in_range;

        // Gating with reset discards a response pending when reset lands in ACCESS.
        in_access = !reset && (state == ST_ACCESS);
        rsp_rdata = (!cur_we && cur_in_range) ? bus_read_data : '0;
        rsp_err   = !cur_in_range;

        m0_rsp_valid = in_access && !cur_g;
        m1_rsp_valid = in_access &&  cur_g;
        m0_rsp_rdata = m0_rsp_valid ? rsp_rdata : m0_rdata_q;
        m1_rsp_rdata = m1_rsp_valid ? rsp_rdata : m1_rdata_q;
        m0_rsp_err   = m0_rsp_valid ? rsp_err   : m0_err_q;
        m1_rsp_err   = m1_rsp_valid ? rsp_err   : m1_err_q;

        lock_cnt_inc = lock_cnt + CNT_ONE;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= ST_IDLE;
            last_grant   <= 1'b1;
            lock_held    <= 1'b0;
            lock_owner   <= 1'b0;
            lock_cnt     <= '0;
            cur_g        <= 1'b0;
            cur_we       <= 1'b0;
            cur_in_range <= 1'b0;
            m0_rdata_q   <= '0;
            m1_rdata_q   <= '0;
            m0_err_q     <= 1'b0;
            m1_err_q     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_any) begin
                        cur_g        <= g;
                        cur_we       <= sel_we;
                        cur_in_range <= sel_in_range;
                        last_grant   <= g;
                        state        <= ST_ACCESS;
                        // The beat that would reach MAX_LOCK_BEATS releases the lock instead.
                        if (sel_lock && (lock_cnt_inc < CNT_MAX)) begin
                            lock_held  <= 1'b1;
                            lock_owner <= g;
                            lock_cnt   <= lock_cnt_inc;
                        end else begin
                            lock_held  <= 1'b0;
                            lock_owner <= 1'b0;
                            lock_cnt   <= '0;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    if (m0_rsp_valid) begin
                        m0_rdata_q <= rsp_rdata;
                        m0_err_q   <= rsp_err;
                    end
                    if (m1_rsp_valid) begin
                        m1_rdata_q <= rsp_rdata;
                        m1_err_q   <= rsp_err;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Directed bench for data_memory_arbiter: arbitration order, locking, range errors and
// reset during an access, against a small word memory attached to the bus.
module tb_data_memory_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        m0_req_valid = 1'b0, m1_req_valid = 1'b0;
    logic        m0_req_ready, m1_req_ready;
    logic [31:0] m0_addr = '0, m1_addr = '0, m0_wdata = '0, m1_wdata = '0;
    logic [3:0]  m0_byte_en = '0, m1_byte_en = '0;
    logic        m0_we = 1'b0, m1_we = 1'b0, m0_lock = 1'b0, m1_lock = 1'b0;
    logic        m0_rsp_valid, m1_rsp_valid, m0_rsp_err, m1_rsp_err;
    logic [31:0] m0_rsp_rdata, m1_rsp_rdata;
    logic [31:0] bus_address, bus_write_data, bus_read_data;
    logic [3:0]  bus_byte_enable;
    logic        bus_read_enable, bus_write_enable;

    logic [31:0] mem [0:4095];
    int          total = 0;
    int          bad = 0;
    int          grants[$];
    logic [63:0] rsps[$];
    int          wr_cnt = 0;
    int          pend = -1;

    data_memory_arbiter #(
        .DATA_BEGIN(32'h0000_2000),
        .DATA_END(32'h0000_3FFF),
        .MAX_LOCK_BEATS(8)
    ) dut (
        .clock(clk), .reset(reset),
        .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_byte_en(m0_byte_en), .m0_we(m0_we), .m0_lock(m0_lock),
        .m0_rsp_valid(m0_rsp_valid), .m0_rsp_rdata(m0_rsp_rdata), .m0_rsp_err(m0_rsp_err),
        .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_byte_en(m1_byte_en), .m1_we(m1_we), .m1_lock(m1_lock),
        .m1_rsp_valid(m1_rsp_valid), .m1_rsp_rdata(m1_rsp_rdata), .m1_rsp_err(m1_rsp_err),
        .bus_address(bus_address), .bus_write_data(bus_write_data),
        .bus_byte_enable(bus_byte_enable), .bus_read_enable(bus_read_enable),
        .bus_write_enable(bus_write_enable), .bus_read_data(bus_read_data)
    );

    always #5 clk = ~clk;

    // Word memory, refilled with a known pattern while reset is high; 0x2000 holds 0xDEADBEEF.
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4096; i++) mem[i] <= 32'h1000_0000 + i;
            mem[2048] <= 32'hDEADBEEF;
        end else if (bus_write_enable) begin
            for (int b = 0; b < 4; b++)
                if (bus_byte_enable[b]) mem[bus_address[13:2]][8*b +: 8] <= bus_write_data[8*b +: 8];
        end
        bus_read_data <= mem[bus_address[13:2]];
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] rsp_word(input logic who, input logic err, input logic [31:0] rd);
        return {30'b0, who, err, rd};
    endfunction

    // Every response must go to the requester granted on the previous cycle, never during reset.
    always @(negedge clk) begin
        int got;
        got = (m0_rsp_valid && m1_rsp_valid) ? 2 : m0_rsp_valid ? 0 : m1_rsp_valid ? 1 : -1;
        check("rsp_owner", got, reset ? -1 : pend);
        check("one_ready", m0_req_ready && m1_req_ready, 0);
        pend = reset ? -1 : (m0_req_ready ? 0 : (m1_req_ready ? 1 : -1));
        if (m0_req_ready) grants.push_back(0);
        if (m1_req_ready) grants.push_back(1);
        if (m0_rsp_valid) rsps.push_back(rsp_word(1'b0, m0_rsp_err, m0_rsp_rdata));
        if (m1_rsp_valid) rsps.push_back(rsp_word(1'b1, m1_rsp_err, m1_rsp_rdata));
        if (bus_write_enable) wr_cnt++;
    end

    task automatic issue(input int who, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] be, input logic we, input logic lk);
        int  n;
        logic acc;
        n = 0;
        if (who == 0) begin
            m0_req_valid = 1'b1; m0_addr = a; m0_wdata = d; m0_byte_en = be; m0_we = we; m0_lock = lk;
        end else begin
            m1_req_valid = 1'b1; m1_addr = a; m1_wdata = d; m1_byte_en = be; m1_we = we; m1_lock = lk;
        end
        do begin
            @(negedge clk);
            n++;
            acc = (who == 0) ? m0_req_ready : m1_req_ready;
        end while (!acc && n < 60);
        if (!acc) check("accept_timeout", 0, 1);
        @(posedge clk); #1;
        if (who == 0) m0_req_valid = 1'b0;
        else          m1_req_valid = 1'b0;
    endtask

    task automatic drain();
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        grants.delete();
        rsps.delete();
        wr_cnt = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        repeat (2) @(posedge clk);
        #1;
        m0_req_valid = 1'b1;
        @(negedge clk);
        check("rst_m0_ready", m0_req_ready, 0);
        check("rst_rsp_valid", {m0_rsp_valid, m1_rsp_valid}, 0);
        check("rst_rdata", {m0_rsp_rdata, m1_rsp_rdata}, 0);
        check("rst_err", {m0_rsp_err, m1_rsp_err}, 0);
        check("rst_bus_en", {bus_read_enable, bus_write_enable}, 0);
        @(posedge clk); #1;
        m0_req_valid = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        check("idle_no_req", {m0_req_ready, m1_req_ready, bus_read_enable}, 0);
        @(posedge clk); #1;

        // Both requesters continuously valid right after reset: m0 wins the first tie.
        clear_logs();
        fork
            begin
                issue(0, 32'h2000, 0, 4'hF, 1'b0, 1'b0);
                issue(0, 32'h2004, 0, 4'hF, 1'b0, 1'b0);
            end
            begin
                issue(1, 32'h2008, 0, 4'hF, 1'b0, 1'b0);
                issue(1, 32'h200C, 0, 4'hF, 1'b0, 1'b0);
            end
        join
        drain();
        check("t2_ngrants", grants.size(), 4);
        for (int i = 0; i < 4 && i < grants.size(); i++) check("t2_grant", grants[i], i % 2);
        check("t2_nrsps", rsps.size(), 4);
        if (rsps.size() == 4) begin
            check("t2_rsp0", rsps[0], rsp_word(1'b0, 1'b0, 32'hDEADBEEF));
            check("t2_rsp1", rsps[1], rsp_word(1'b1, 1'b0, 32'h1000_0802));
            check("t2_rsp2", rsps[2], rsp_word(1'b0, 1'b0, 32'h1000_0801));
            check("t2_rsp3", rsps[3], rsp_word(1'b1, 1'b0, 32'h1000_0803));
        end

        // Single m0 read with cycle-exact timing.
        m0_req_valid = 1'b1; m0_addr = 32'h2000; m0_we = 1'b0; m0_lock = 1'b0; m0_byte_en = 4'hF;
        @(negedge clk);
        check("t1_ready", m0_req_ready, 1);
        check("t1_rd_en", bus_read_enable, 1);
        check("t1_wr_en", bus_write_enable, 0);
        check("t1_addr", bus_address, 32'h2000);
        @(posedge clk); #1;
        m0_req_valid = 1'b0;
        @(negedge clk);
        check("t1_rsp_valid", {m0_rsp_valid, m1_rsp_valid}, 2'b10);
        check("t1_rdata", m0_rsp_rdata, 32'hDEADBEEF);
        check("t1_err", m0_rsp_err, 0);
        check("t1_ready_access", m0_req_ready, 0);
        @(negedge clk);
        check("t1_hold_valid", m0_rsp_valid, 0);
        check("t1_hold_rdata", m0_rsp_rdata, 32'hDEADBEEF);
        drain();

        // Locked 4-beat m1 write burst while m0 waits.
        clear_logs();
        fork
            begin
                issue(1, 32'h2100, 32'hA0A0A0A0, 4'hF, 1'b1, 1'b1);
                issue(1, 32'h2104, 32'hA1A1A1A1, 4'hF, 1'b1, 1'b1);
                issue(1, 32'h2108, 32'hA2A2A2A2, 4'hF, 1'b1, 1'b1);
                issue(1, 32'h210C, 32'hA3A3A3A3, 4'h3, 1'b1, 1'b0);
            end
            begin
                @(posedge clk); #1;
                issue(0, 32'h2010, 0, 4'hF, 1'b0, 1'b0);
            end
        join
        drain();
        check("t3_ngrants", grants.size(), 5);
        for (int i = 0; i < 5 && i < grants.size(); i++) check("t3_grant", grants[i], (i == 4) ? 0 : 1);
        check("t3_wr_cnt", wr_cnt, 4);
        check("t3_mem0", mem[12'h840], 32'hA0A0A0A0);
        check("t3_mem1", mem[12'h841], 32'hA1A1A1A1);
        check("t3_mem2", mem[12'h842], 32'hA2A2A2A2);
        check("t3_mem3_be", mem[12'h843], 32'h1000A3A3);
        if (rsps.size() == 5) begin
            check("t3_wr_rsp", rsps[0], rsp_word(1'b1, 1'b0, 32'h0));
            check("t3_m0_rsp", rsps[4], rsp_word(1'b0, 1'b0, 32'h1000_0804));
        end else check("t3_nrsps", rsps.size(), 5);

        // Out-of-range write below and read above the window.
        clear_logs();
        issue(0, 32'h1FFC, 32'h55555555, 4'hF, 1'b1, 1'b0);
        issue(0, 32'h4000, 32'h0, 4'hF, 1'b0, 1'b0);
        drain();
        check("t5_wr_cnt", wr_cnt, 0);
        check("t5_mem", mem[12'h7FF], 32'h1000_07FF);
        check("t5_nrsps", rsps.size(), 2);
        if (rsps.size() == 2) begin
            check("t5_rsp_wr", rsps[0], rsp_word(1'b0, 1'b1, 32'h0));
            check("t5_rsp_rd", rsps[1], rsp_word(1'b0, 1'b1, 32'h0));
        end

        // 12 locked m1 beats: forced release after the 8th lets m0 in.
        clear_logs();
        fork
            begin
                for (int i = 0; i < 12; i++) issue(1, 32'h2200 + 4 * i, 0, 4'hF, 1'b0, 1'b1);
            end
            begin
                @(posedge clk); #1;
                issue(0, 32'h2000, 0, 4'hF, 1'b0, 1'b0);
            end
        join
        drain();
        check("t4_ngrants", grants.size(), 13);
        for (int i = 0; i < 13 && i < grants.size(); i++) check("t4_grant", grants[i], (i == 8) ? 0 : 1);

        // m1 still owns the lock (4 beats in) while idle, so m0 must keep waiting.
        m0_req_valid = 1'b1; m0_addr = 32'h2000; m0_we = 1'b0; m0_lock = 1'b0;
        cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (m0_req_ready) cnt++;
        end
        check("lock_persist", cnt, 0);

        // Reset lands in the ACCESS cycle of a locked m1 read.
        @(posedge clk); #1;
        m1_req_valid = 1'b1; m1_addr = 32'h2204; m1_we = 1'b0; m1_lock = 1'b1;
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!m1_req_ready && cnt < 10);
        check("t6_m1_grant", m1_req_ready, 1);
        @(posedge clk); #1;
        m1_req_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check("t6_rsp_in_reset", {m0_rsp_valid, m1_rsp_valid}, 0);
        check("t6_ready_in_reset", m0_req_ready, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("t6_no_rsp_after", m1_rsp_valid, 0);
        check("t6_lock_free", m0_req_ready, 1);
        @(posedge clk); #1;
        m0_req_valid = 1'b0;
        @(negedge clk);
        check("t6_m0_rsp", {m0_rsp_valid, m0_rsp_rdata}, {1'b1, 32'hDEADBEEF});
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
